ram16k_bist: RTL and testbench

//  Synthesizable initiator for the 16k x 16 single-port RAM (address/data/wren in, q out).

---
 rtl/ram_bist_pkg.sv | 30 +++
 rtl/ram16k_bist_if.sv | 26 ++
 rtl/ram_bist_check.sv | 81 ++++++++
 rtl/ram16k_bist.sv | 144 ++++++++++++++
 tb/tb_ram16k_bist.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and the expected-data generator for the RAM self-test.
package ram_bist_pkg;

  // Widest data/address the expected-value generator supports; callers truncate.
  localparam int unsigned ExpW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_t;

  typedef enum logic [1:0] {
    PAT_ZEROS = 2'd0,
    PAT_ONES  = 2'd1,
    PAT_ADDR  = 2'd2
  } pattern_t;

  function automatic logic [ExpW-1:0] exp_data(pattern_t pat, logic [ExpW-1:0] addr);
    case (pat)
      PAT_ZEROS: return '0;
      PAT_ONES:  return '1;
      PAT_ADDR:  return addr;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/ram16k_bist_if.sv
// Single-port RAM port as seen from the BIST (master) and the RAM (slave).
interface ram16k_bist_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
) ();

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output ram_address,
    output ram_data,
    output ram_wren,
    input  ram_q
  );

  modport slave (
    input  ram_address,
    input  ram_data,
    input  ram_wren,
    output ram_q
  );

endinterface

// File: rtl/ram_bist_check.sv
// Read-latency delay line, comparator, saturating error counter and first-fail capture.
module ram_bist_check
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clock,
  input  logic              sclr_n,
  input  logic              clr_i,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  pattern_t          pat_i,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic              mism_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [1:0]        fail_pat_o
);

  logic              vld_q [RD_LAT];
  logic [DATA_W-1:0] exp_q [RD_LAT];
  logic [ADDR_W-1:0] adr_q [RD_LAT];
  pattern_t          pat_q [RD_LAT];

  logic [ERR_W-1:0]  err_q;
  logic              seen_q;
  logic [ADDR_W-1:0] fail_addr_q;
  pattern_t          fail_pat_q;

  always_ff @(posedge clock) begin
    if (!sclr_n || clr_i) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        vld_q[i] <= 1'b0;
        exp_q[i] <= '0;
        adr_q[i] <= '0;
        pat_q[i] <= PAT_ZEROS;
      end
    end else begin
      vld_q[0] <= rd_valid_i;
      exp_q[0] <= exp_i;
      adr_q[0] <= addr_i;
      pat_q[0] <= pat_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        adr_q[i] <= adr_q[i-1];
        pat_q[i] <= pat_q[i-1];
      end
    end
  end

  // The last tap lines up with the RAM output for the address it describes.
  assign mism_o = vld_q[RD_LAT-1] && (ram_q_i != exp_q[RD_LAT-1]);

  always_ff @(posedge clock) begin
    if (!sclr_n || clr_i) begin
      err_q       <= '0;
      seen_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_pat_q  <= PAT_ZEROS;
    end else if (mism_o) begin
      if (err_q != '1) begin
        err_q <= err_q + ERR_W'(1);
      end
      if (!seen_q) begin
        seen_q      <= 1'b1;
        fail_addr_q <= adr_q[RD_LAT-1];
        fail_pat_q  <= pat_q[RD_LAT-1];
      end
    end
  end

  assign err_cnt_o   = err_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_pat_o  = fail_pat_q;

endmodule

// File: rtl/ram16k_bist.sv
// RAM BIST initiator: write/verify passes of zeros, ones and address-as-data.
module ram16k_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clock,
  input  logic              sclr_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [1:0]        fail_pat,
  ram16k_bist_if.master     ram_if
);

  localparam logic [ADDR_W-1:0] LastAddr  = '1;
  localparam logic [7:0]        DrainLast = 8'(RD_LAT - 1);

  function automatic logic [DATA_W-1:0] exp_word(pattern_t p, logic [ADDR_W-1:0] a);
    return DATA_W'(exp_data(p, ExpW'(a)));
  endfunction

  state_t            state_q;
  pattern_t          pat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wren_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [7:0]        drain_q;

  logic [ADDR_W-1:0] addr_nxt;
  pattern_t          pat_nxt;
  logic              clr;
  logic              mism;

  assign addr_nxt = addr_q + ADDR_W'(1);
  assign pat_nxt  = (pat_q == PAT_ZEROS) ? PAT_ONES : PAT_ADDR;
  assign clr      = ((state_q == StIdle) || (state_q == StDone)) && start;

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state_q <= StIdle;
      pat_q   <= PAT_ZEROS;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StWrite;
            pat_q   <= PAT_ZEROS;
            addr_q  <= '0;
            data_q  <= exp_word(PAT_ZEROS, '0);
            wren_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        StWrite: begin
          if (addr_q == LastAddr) begin
            state_q <= StRead;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
          end else begin
            addr_q <= addr_nxt;
            data_q <= exp_word(pat_q, addr_nxt);
          end
        end
        StRead: begin
          if (addr_q == LastAddr) begin
            state_q <= StDrain;
            addr_q  <= '0;
            drain_q <= '0;
          end else begin
            addr_q <= addr_nxt;
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            if (pat_q == PAT_ADDR) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              // The final compare lands on this same edge, so fold it in here.
              pass_q  <= (err_cnt == '0) && !mism;
            end else begin
              state_q <= StWrite;
              pat_q   <= pat_nxt;
              addr_q  <= '0;
              data_q  <= exp_word(pat_nxt, '0);
              wren_q  <= 1'b1;
            end
          end else begin
            drain_q <= drain_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ram_bist_check #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .ERR_W  (ERR_W)
  ) u_check (
    .clock       (clock),
    .sclr_n      (sclr_n),
    .clr_i       (clr),
    .rd_valid_i  (state_q == StRead),
    .exp_i       (exp_word(pat_q, addr_q)),
    .addr_i      (addr_q),
    .pat_i       (pat_q),
    .ram_q_i     (ram_if.ram_q),
    .mism_o      (mism),
    .err_cnt_o   (err_cnt),
    .fail_addr_o (fail_addr),
    .fail_pat_o  (fail_pat)
  );

  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign ram_if.ram_address = addr_q;
  assign ram_if.ram_data    = data_q;
  assign ram_if.ram_wren    = wren_q;

endmodule

// File: tb/tb_ram16k_bist.sv
// Directed bench for ram16k_bist with a 16-word RAM model and injectable faults.
module tb_ram16k_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sclr_n;
  logic        start;
  logic        start3;
  int          fault;

  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [3:0]  fail_addr;
  logic [1:0]  fail_pat;

  logic        busy3, done3, pass3;
  logic [2:0]  err_cnt3;
  logic [3:0]  fail_addr3;
  logic [1:0]  fail_pat3;

  ram16k_bist_if #(.ADDR_W(4), .DATA_W(16)) ram_if ();
  ram16k_bist_if #(.ADDR_W(4), .DATA_W(16)) ram3_if ();

  ram16k_bist #(.ADDR_W(4), .DATA_W(16), .RD_LAT(1), .ERR_W(16)) dut (
    .clock     (clk),
    .sclr_n    (sclr_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_pat  (fail_pat),
    .ram_if    (ram_if)
  );

  ram16k_bist #(.ADDR_W(4), .DATA_W(16), .RD_LAT(1), .ERR_W(3)) dut3 (
    .clock     (clk),
    .sclr_n    (sclr_n),
    .start     (start3),
    .busy      (busy3),
    .done      (done3),
    .pass      (pass3),
    .err_cnt   (err_cnt3),
    .fail_addr (fail_addr3),
    .fail_pat  (fail_pat3),
    .ram_if    (ram3_if)
  );

  // RAM model, one register of read latency; faults applied on the read port.
  logic [15:0] mem [16];
  logic [15:0] q_raw;
  logic [3:0]  q_addr;
  logic [15:0] q_mod;
  always @(posedge clk) begin
    if (ram_if.ram_wren) mem[ram_if.ram_address] <= ram_if.ram_data;
    q_raw  <= mem[ram_if.ram_address];
    q_addr <= ram_if.ram_address;
  end
  always_comb begin
    q_mod = q_raw;
    if (fault == 1) q_mod = q_raw | 16'h0001;
    else if (fault == 2 && q_addr == 4'd5) q_mod = 16'h0000;
  end
  assign ram_if.ram_q = q_mod;

  // Second RAM returns the complement of every stored word.
  logic [15:0] mem3 [16];
  logic [15:0] q3;
  always @(posedge clk) begin
    if (ram3_if.ram_wren) mem3[ram3_if.ram_address] <= ram3_if.ram_data;
    q3 <= ~mem3[ram3_if.ram_address];
  end
  assign ram3_if.ram_q = q3;

  int n_chk;
  int n_fail;
  logic first_wren;
  logic [3:0] first_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_test(output int cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    first_wren = ram_if.ram_wren;
    first_addr = ram_if.ram_address;
    cycles = 0;
    while (busy && cycles < 1000) begin
      cycles++;
      tick();
    end
  endtask

  typedef struct {
    string      name;
    int         fault;
    int         cycles;
    logic       pass;
    int         err;
    int         faddr;
    int         fpat;
  } vec_t;

  vec_t vecs [4];
  int   cyc;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    sclr_n = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    fault  = 0;

    vecs[0] = '{"fault_free", 0, 99, 1'b1, 0, 0, 0};
    vecs[1] = '{"bit0_sa1",   1, 99, 1'b0, 24, 0, 0};
    vecs[2] = '{"word5_sa0",  2, 99, 1'b0, 2, 5, 1};
    vecs[3] = '{"clean_rerun", 0, 99, 1'b1, 0, 0, 0};

    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_faddr", 32'(fail_addr), 0);
    check("rst_fpat", 32'(fail_pat), 0);
    check("rst_wren", 32'(ram_if.ram_wren), 0);
    check("rst_addr", 32'(ram_if.ram_address), 0);
    check("rst_data", 32'(ram_if.ram_data), 0);
    sclr_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      fault = vecs[i].fault;
      run_test(cyc);
      check({vecs[i].name, "_first_wren"}, 32'(first_wren), 1);
      check({vecs[i].name, "_first_addr"}, 32'(first_addr), 0);
      check({vecs[i].name, "_cycles"}, cyc, vecs[i].cycles);
      check({vecs[i].name, "_done"}, 32'(done), 1);
      check({vecs[i].name, "_pass"}, 32'(pass), 32'(vecs[i].pass));
      check({vecs[i].name, "_err"}, 32'(err_cnt), vecs[i].err);
      check({vecs[i].name, "_faddr"}, 32'(fail_addr), vecs[i].faddr);
      check({vecs[i].name, "_fpat"}, 32'(fail_pat), vecs[i].fpat);
      check({vecs[i].name, "_idle_wren"}, 32'(ram_if.ram_wren), 0);
      check({vecs[i].name, "_idle_addr"}, 32'(ram_if.ram_address), 0);
      check({vecs[i].name, "_idle_data"}, 32'(ram_if.ram_data), 0);
    end

    // Reset while reading back the ONES pattern.
    fault = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 55; i++) tick();
    check("mid_busy", 32'(busy), 1);
    check("mid_err", 32'(err_cnt), 16);
    check("mid_wren", 32'(ram_if.ram_wren), 0);
    sclr_n = 1'b0;
    tick();
    check("mid_rst_wren", 32'(ram_if.ram_wren), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_err", 32'(err_cnt), 0);
    check("mid_rst_done", 32'(done), 0);
    sclr_n = 1'b1;
    tick();
    tick();
    check("mid_no_resume", 32'(busy), 0);
    run_test(cyc);
    check("rerun_cycles", cyc, 99);
    check("rerun_err", 32'(err_cnt), 24);
    check("rerun_fpat", 32'(fail_pat), 0);

    // Start held high: one DONE cycle, then relaunch.
    fault = 0;
    start = 1'b1;
    tick();
    cyc = 0;
    while (busy && cyc < 1000) begin
      cyc++;
      tick();
    end
    check("held_cycles", cyc, 99);
    check("held_done", 32'(done), 1);
    check("held_pass", 32'(pass), 1);
    tick();
    check("held_relaunch_busy", 32'(busy), 1);
    check("held_relaunch_done", 32'(done), 0);

    // Start pulses while busy are ignored.
    cyc = 1;
    while (busy && cyc < 1000) begin
      start = ((cyc % 30) == 10);
      tick();
      if (busy) cyc++;
    end
    start = 1'b0;
    check("pulse_cycles", cyc, 99);
    check("pulse_done", 32'(done), 1);
    check("pulse_pass", 32'(pass), 1);
    tick();
    check("pulse_stay_done", 32'(done), 1);
    check("pulse_stay_idle", 32'(busy), 0);

    // Narrow error counter with every word failing.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 0;
    while (busy3 && cyc < 1000) begin
      cyc++;
      tick();
    end
    check("sat_cycles", cyc, 99);
    check("sat_done", 32'(done3), 1);
    check("sat_err", 32'(err_cnt3), 7);
    check("sat_pass", 32'(pass3), 0);
    check("sat_faddr", 32'(fail_addr3), 0);
    check("sat_fpat", 32'(fail_pat3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
